uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` transmitter among N byte-stream requesters. Requests are served round-robin, and a multi-byte packet keeps the grant until its last byte has been sent. Each byte handoff to `uart_tx` is sequenced by pulsing `tx_start`, then waiting for `tx_done_tick`. The block sits between client logic (command responders, debug printers) and `uart_tx`, which runs from the same clock, reset and `baud_gen` tick.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// the character width carried on the line.
package uart_pkg;

  localparam int UART_DBIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted request found when
// searching upward from ptr+1 (mod N) wins.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N byte-stream requesters: round-robin between
// packets, grant held until the last byte of a packet (or a hold timeout).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N            = 4,
  parameter  int HOLD_TIMEOUT = 1024,
  localparam int IW           = (N > 1) ? $clog2(N) : 1,
  localparam int CW           = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*UART_DBIT-1:0] req_data,
  input  logic [N-1:0]           req_last,
  output logic [N-1:0]           req_ready,
  output logic                   tx_start,
  output logic [UART_DBIT-1:0]   tx_din,
  input  logic                   tx_done_tick,
  output logic [IW-1:0]          grant_id,
  output logic                   busy
);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 last_q;

  logic [N-1:0]         pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 load_en;
  logic [IW-1:0]        load_idx;
  logic                 ptr_ld;
  logic                 cnt_clr;
  logic                 cnt_inc;

  logic [UART_DBIT-1:0] data_arr [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_arr[i] = req_data[UART_DBIT*i +: UART_DBIT];
    end
  end

  rr_pick #(.N(N)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    load_en   = 1'b0;
    load_idx  = grant_id;
    ptr_ld    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gate keeps req_ready low while reset is held
        if (pick_any && reset_n) begin
          req_ready = pick_gnt;
          load_en   = 1'b1;
          load_idx  = pick_idx;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          if (last_q) begin
            ptr_ld  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_clr = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_valid[grant_id]) begin
          req_ready[grant_id] = 1'b1;
          load_en             = 1'b1;
          state_d             = LOAD;
        end else if (cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
          ptr_ld  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, counter and byte latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(N - 1);
      cnt_q    <= '0;
      last_q   <= 1'b0;
      tx_din   <= '0;
      grant_id <= '0;
      tx_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_start <= (state_d == LOAD);
      if (load_en) begin
        tx_din   <= data_arr[load_idx];
        last_q   <= req_last[load_idx];
        grant_id <= load_idx;
      end
      if (ptr_ld) begin
        ptr_q <= grant_id;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with queue-driven requesters and a
// behavioural uart_tx that returns tx_done_tick after a full frame.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int HT      = 8;
  localparam int IW      = 2;
  localparam int BIT_CYC = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_din;
  logic           tx_done_tick;
  logic [IW-1:0]  grant_id;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .HOLD_TIMEOUT(HT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [8:0] rq [N][$];
  logic [9:0] sb [$];
  int         acc_cnt [N];
  int         acc_log [$];
  int         done_log [$];
  int         n_start = 0;
  int         last_acc_cyc = -10;
  int         last_acc_id = 0;
  bit         uart_busy = 1'b0;
  int         uart_cnt = 0;
  logic [9:0] frame = '0;
  logic [9:0] last_frame = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int rq_pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic push(input int id, input logic [7:0] d, input logic last, input bit expect_tx);
    rq[id].push_back({last, d});
    if (expect_tx) sb.push_back({2'(id), d});
  endtask

  task automatic clear_logs();
    acc_log.delete();
    done_log.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  task automatic flush_env();
    for (int i = 0; i < N; i++) rq[i].delete();
    sb.delete();
    uart_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush_env();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((sb.size() != 0 || busy || uart_busy || rq_pending() != 0) && k < max) begin
      tick();
      k++;
    end
    check("drain_timeout", k < max, 1);
  endtask

  task automatic wait_acc(input int id, input int n, input int max);
    int k = 0;
    while (acc_cnt[id] < n && k < max) begin
      tick();
      k++;
    end
    check("wait_acc_timeout", k < max, 1);
  endtask

  // Requester drivers, uart_tx model and output monitor, all on the falling edge
  initial begin
    logic [9:0] e;
    tx_done_tick = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      tx_done_tick = 1'b0;
      if (tx_start) begin
        n_start++;
        check("start_overlap", uart_busy, 0);
        check("start_timing", cyc, last_acc_cyc + 1);
        check("start_id", grant_id, last_acc_id);
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("tx_id", grant_id, e[9:8]);
          check("tx_din", tx_din, e[7:0]);
        end
        uart_busy = 1'b1;
        uart_cnt  = 10 * BIT_CYC;
        frame     = {1'b1, tx_din, 1'b0};
      end else if (uart_busy) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          uart_busy    = 1'b0;
          tx_done_tick = 1'b1;
          last_frame   = frame;
          done_log.push_back(cyc);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          {req_last[i], req_data[8*i +: 8]} = rq[i][0];
        end else begin
          req_valid[i]        = 1'b0;
          req_last[i]         = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
        end
      end
      #1;
      if (req_ready != '0) begin
        check("ready_onehot", $onehot(req_ready), 1);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            check("ready_has_valid", req_valid[i], 1);
            if (rq[i].size() > 0) void'(rq[i].pop_front());
            acc_cnt[i]++;
            acc_log.push_back(cyc);
            last_acc_cyc = cyc;
            last_acc_id  = i;
          end
        end
      end
    end
  end

  initial begin
    clear_logs();
    // Reset then idle
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();
    check("idle_starts", n_start, 0);
    check("idle_busy", busy, 0);
    check("idle_grant", grant_id, 0);
    check("idle_din", tx_din, 8'h00);
    check("idle_ready", req_ready, 0);

    // Single byte from requester 2
    clear_logs();
    push(2, 8'h55, 1'b1, 1'b1);
    drain(200);
    check("single_frame", last_frame, 10'h2AA);
    check("single_busy", busy, 0);
    check("single_acc2", acc_cnt[2], 1);

    // Round-robin across all four requesters
    do_reset();
    clear_logs();
    push(0, 8'hA0, 1'b1, 1'b1);
    push(1, 8'hA1, 1'b1, 1'b1);
    push(2, 8'hA2, 1'b1, 1'b1);
    push(3, 8'hA3, 1'b1, 1'b1);
    push(0, 8'hA4, 1'b1, 1'b1);
    drain(600);
    check("rr_acc0", acc_cnt[0], 2);
    check("rr_acc1", acc_cnt[1], 1);
    check("rr_acc2", acc_cnt[2], 1);
    check("rr_acc3", acc_cnt[3], 1);

    // Hold timeout after an unterminated byte from requester 3
    clear_logs();
    push(3, 8'h33, 1'b0, 1'b1);
    wait_acc(3, 1, 50);
    push(0, 8'h01, 1'b1, 1'b1);
    drain(300);
    check("to_acc3", acc_cnt[3], 1);
    check("to_acc_count", acc_log.size(), 2);
    if (acc_log.size() >= 2 && done_log.size() >= 1)
      check("to_gap", acc_log[1] - done_log[0], 1 + HT);
    else
      check("to_logs", acc_log.size() + done_log.size(), 4);

    // Packet lock while requester 0 also waits
    clear_logs();
    push(1, 8'h10, 1'b0, 1'b1);
    push(1, 8'h11, 1'b0, 1'b1);
    push(1, 8'h12, 1'b1, 1'b1);
    wait_acc(1, 1, 50);
    push(0, 8'h20, 1'b1, 1'b1);
    drain(600);
    check("lock_acc0", acc_cnt[0], 1);
    check("lock_acc1", acc_cnt[1], 3);
    if (acc_log.size() >= 3 && done_log.size() >= 2) begin
      check("lock_hold1", acc_log[1] - done_log[0], 1);
      check("lock_hold2", acc_log[2] - done_log[1], 1);
    end else begin
      check("lock_logs", acc_log.size() + done_log.size(), 8);
    end

    // Reset while a multi-byte packet is in WAIT
    clear_logs();
    push(1, 8'h30, 1'b0, 1'b1);
    push(1, 8'h31, 1'b0, 1'b0);
    push(1, 8'h32, 1'b1, 1'b0);
    wait_acc(1, 1, 50);
    repeat (2) tick();
    check("mid_busy_before", busy, 1);
    reset_n = 1'b0;
    flush_env();
    #1;
    check("rst_start", tx_start, 0);
    check("rst_din", tx_din, 8'h00);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    clear_logs();
    push(1, 8'h41, 1'b1, 1'b0);
    push(0, 8'h40, 1'b1, 1'b1);
    sb.push_back({2'd1, 8'h41});
    drain(300);
    check("post_rst_acc0", acc_cnt[0], 1);
    check("post_rst_acc1", acc_cnt[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
